alu_top: RTL and testbench
==========================

Name: alu_top

Overview:
- Multi-cycle 32-bit integer ALU for the core execute stage.
- Covers RV32I register-register arithmetic/logic and branch comparisons.
- An operation is selected by the 5-bit decoded index Instruction_to_ALU and started by the dat_ready handshake.
- Registered result, flags and a ready indication go back to the control unit.

Parameters:
- None. Data width fixed at 32; operation index width fixed at 5.

Ports:
- soc_clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- dat_ready  input  1  operands/op valid; level, held high until ALU_ready seen
- ALU_dat1  input  32  operand A (rs1)
- ALU_dat2  input  32  operand B (rs2); shifts use [4:0]
- ALU_opcode  input  3  funct3 field; used only with ALU_DECODE_EN
- ALU_opcode_differentiator  input  1  funct7[5]; used only with ALU_DECODE_EN
- ALU_optype  input  1  0 = arith/logic, 1 = branch; used only with ALU_DECODE_EN
- Instruction_to_ALU  input  5  operation index, 0-15 valid
- ALU_overflow  output  1  signed overflow (ADD/SUB only)
- ALU_con_met  output  1  branch condition true
- ALU_zero  output  1  ALU_out == 0
- ALU_err  output  1  illegal operation index
- ALU_ready  output  1  result valid
- ALU_out  output  32  result

Behaviour:
- Clock and reset: one clock domain (soc_clk); reset is asynchronous and active-high.
- On reset:
  - FSM goes to IDLE.
  - All outputs cleared to 0.
  - Operand latches cleared.
  - Reset mid-operation aborts it; no ready pulse is produced.
- FSM states IDLE -> EXEC -> DONE:
  - IDLE: at a posedge with dat_ready=1, latch ALU_dat1, ALU_dat2 and Instruction_to_ALU; go to EXEC.
  - EXEC: at the next posedge, compute from the latched values; register ALU_out and all flags; set ALU_ready=1; go to DONE.
  - DONE: outputs and ALU_ready held while dat_ready=1. The first posedge with dat_ready=0 clears ALU_ready and returns to IDLE. ALU_out and flags keep their values until the next EXEC.
- Latency: ALU_ready is high 2 edges after dat_ready is first sampled. Input changes after the capture edge are ignored.
- Operation index encoding:
  - 0 BEQ (A==B)
  - 1 BNE (A!=B)
  - 2 BLT (signed A<B)
  - 3 BGE (signed A>=B)
  - 4 BLTU (unsigned A<B)
  - 5 BGEU (unsigned A>=B)
  - 6 ADD
  - 7 SUB (A-B)
  - 8 SLL
  - 9 SLT (signed)
  - 10 SLTU
  - 11 XOR
  - 12 SRL
  - 13 SRA (sign-filled)
  - 14 OR
  - 15 AND
- Arithmetic: all results modulo 2^32; shift amount is B[4:0].
- Branch ops (0-5): ALU_con_met = condition; ALU_out = {31'b0, condition}; ALU_overflow = 0.
- Non-branch ops (6-15): ALU_con_met = 0.
- SLT/SLTU: ALU_out = 1 or 0.
- ALU_overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands differ in sign and the result sign differs from A.
  - 0 for all other ops.
- ALU_zero = (ALU_out == 0), updated with every result.
- Illegal index (16-31):
  - ALU_err = 1, ALU_out = 0, other flags 0.
  - Handshake still completes (ALU_ready asserts).
  - ALU_err clears on the next legal operation or on reset.
- dat_ready dropping during EXEC: the operation still completes; FSM then passes through DONE for one cycle with ALU_ready=1 and returns to IDLE.

Optional Feature:
- Macro: ALU_DECODE_EN.
- When defined, for an illegal Instruction_to_ALU (16-31) the index is derived from the raw fields instead of raising ALU_err:
  - ALU_optype=1 (branch): funct3 000/001/100/101/110/111 map to 0/1/2/3/4/5; funct3 010/011 raise ALU_err.
  - ALU_optype=0 (arith/logic):
    - funct3 000 -> 6, or 7 if differentiator=1
    - 001 -> 8
    - 010 -> 9
    - 011 -> 10
    - 100 -> 11
    - 101 -> 12, or 13 if differentiator=1
    - 110 -> 14
    - 111 -> 15
- When not defined: ALU_opcode, ALU_opcode_differentiator and ALU_optype are ignored; index 16-31 always sets ALU_err.

Test Plan:
- ADD 0x5 + 0x3 (idx 6) -> ALU_out 0x00000008, overflow 0, zero 0, ready 2 edges after capture. SUB same operands (idx 7) -> 0x00000002.
- ADD 0x7FFFFFFF + 0x1 -> 0x80000000, overflow 1. SUB 0x3 - 0x3 -> 0x0, zero 1.
- Shifts with B=4:
  - SLL 0x3 by 2 -> 0xC.
  - SRL 0xF0000000 -> 0x0F000000.
  - SRA 0xF0000000 -> 0xFF000000.
  - XOR 0x0F0F0F0F, 0xFF00FF00 -> 0xF00FF00F; OR -> 0xFF0FFF0F; AND -> 0x0F000F00.
- SLT 3 vs 5 -> 1. SLTU 0xFFFFFFFF vs 1 -> 0, zero 1.
- Branches:
  - BEQ 5,5 -> con_met 1, out 1.
  - BNE 5,3 -> con_met 1.
  - BLT 0xFFFFFFFD, 0 -> con_met 1.
  - BGE 0, 0xFFFFFFFD -> con_met 1.
  - BLTU 3,5 -> con_met 1.
  - BGEU 3,5 -> con_met 0, zero 1.
- Illegal index 16 without the macro -> ALU_err 1, ALU_out 0, ready asserts.
- Reset asserted during EXEC -> all outputs 0 immediately; no ALU_ready pulse.
- Hold dat_ready high in DONE -> ALU_ready stays 1 with no re-trigger. Drop dat_ready -> ALU_ready clears next edge.

Source files
------------

// File: rtl/alu_top.sv
// Multi-cycle RV32I integer ALU: operands captured on dat_ready, result registered one cycle later.
// Optional raw-field decode of out-of-range operation indices is enabled by defining ALU_DECODE_EN.
module alu_top (
    input  logic        soc_clk,
    input  logic        reset,
    input  logic        dat_ready,
    input  logic [31:0] ALU_dat1,
    input  logic [31:0] ALU_dat2,
    input  logic [2:0]  ALU_opcode,
    input  logic        ALU_opcode_differentiator,
    input  logic        ALU_optype,
    input  logic [4:0]  Instruction_to_ALU,
    output logic        ALU_overflow,
    output logic        ALU_con_met,
    output logic        ALU_zero,
    output logic        ALU_err,
    output logic        ALU_ready,
    output logic [31:0] ALU_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] IDX_ILLEGAL = 5'd16;

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic [31:0] a_q, b_q;
    logic [4:0]  idx_q;
    logic [4:0]  eff_idx;

    logic [31:0] out_q, out_d;
    logic        ovf_q, ovf_d;
    logic        cm_q, cm_d;
    logic        zero_q, zero_d;
    logic        err_q, err_d;

    logic [31:0] sum, diff;
    logic [4:0]  shamt;
    logic        eq, lt_s, lt_u;

    // Effective operation index; bit 4 set means the operation is illegal.
    always_comb begin
        eff_idx = Instruction_to_ALU;
`ifdef ALU_DECODE_EN
        if (Instruction_to_ALU[4]) begin
            if (ALU_optype) begin
                case (ALU_opcode)
                    3'b000:  eff_idx = 5'd0;
                    3'b001:  eff_idx = 5'd1;
                    3'b100:  eff_idx = 5'd2;
                    3'b101:  eff_idx = 5'd3;
                    3'b110:  eff_idx = 5'd4;
                    3'b111:  eff_idx = 5'd5;
                    default: eff_idx = IDX_ILLEGAL;
                endcase
            end else begin
                case (ALU_opcode)
                    3'b000:  eff_idx = ALU_opcode_differentiator ? 5'd7 : 5'd6;
                    3'b001:  eff_idx = 5'd8;
                    3'b010:  eff_idx = 5'd9;
                    3'b011:  eff_idx = 5'd10;
                    3'b100:  eff_idx = 5'd11;
                    3'b101:  eff_idx = ALU_opcode_differentiator ? 5'd13 : 5'd12;
                    3'b110:  eff_idx = 5'd14;
                    default: eff_idx = 5'd15;
                endcase
            end
        end
`else
        if (Instruction_to_ALU[4]) begin
            eff_idx = IDX_ILLEGAL;
        end
`endif
    end

`ifndef ALU_DECODE_EN
    logic unused_decode_fields;
    assign unused_decode_fields = ^{ALU_opcode, ALU_opcode_differentiator, ALU_optype};
`endif

    // Handshake FSM
    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        case (state_q)
            IDLE: begin
                ready_d = 1'b0;
                if (dat_ready) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = DONE;
                ready_d = 1'b1;
            end
            DONE: begin
                if (!dat_ready) begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    // Datapath evaluated from the latched operands
    always_comb begin
        sum   = a_q + b_q;
        diff  = a_q - b_q;
        shamt = b_q[4:0];
        eq    = (a_q == b_q);
        lt_s  = ($signed(a_q) < $signed(b_q));
        lt_u  = (a_q < b_q);
        out_d = 32'd0;
        ovf_d = 1'b0;
        cm_d  = 1'b0;
        err_d = 1'b0;
        if (idx_q[4]) begin
            err_d = 1'b1;
        end else begin
            case (idx_q[3:0])
                4'd0: begin cm_d = eq;    out_d = {31'd0, eq};    end
                4'd1: begin cm_d = !eq;   out_d = {31'd0, !eq};   end
                4'd2: begin cm_d = lt_s;  out_d = {31'd0, lt_s};  end
                4'd3: begin cm_d = !lt_s; out_d = {31'd0, !lt_s}; end
                4'd4: begin cm_d = lt_u;  out_d = {31'd0, lt_u};  end
                4'd5: begin cm_d = !lt_u; out_d = {31'd0, !lt_u}; end
                4'd6: begin
                    out_d = sum;
                    ovf_d = (a_q[31] == b_q[31]) && (sum[31] != a_q[31]);
                end
                4'd7: begin
                    out_d = diff;
                    ovf_d = (a_q[31] != b_q[31]) && (diff[31] != a_q[31]);
                end
                4'd8:    out_d = a_q << shamt;
                4'd9:    out_d = {31'd0, lt_s};
                4'd10:   out_d = {31'd0, lt_u};
                4'd11:   out_d = a_q ^ b_q;
                4'd12:   out_d = a_q >> shamt;
                4'd13:   out_d = $unsigned($signed(a_q) >>> shamt);
                4'd14:   out_d = a_q | b_q;
                default: out_d = a_q & b_q;
            endcase
        end
        // An illegal operation reports only ALU_err.
        zero_d = !err_d && (out_d == 32'd0);
    end

    always_ff @(posedge soc_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            idx_q   <= 5'd0;
            out_q   <= 32'd0;
            ovf_q   <= 1'b0;
            cm_q    <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            if (state_q == IDLE && dat_ready) begin
                a_q   <= ALU_dat1;
                b_q   <= ALU_dat2;
                idx_q <= eff_idx;
            end
            if (state_q == EXEC) begin
                out_q  <= out_d;
                ovf_q  <= ovf_d;
                cm_q   <= cm_d;
                zero_q <= zero_d;
                err_q  <= err_d;
            end
        end
    end

    assign ALU_out      = out_q;
    assign ALU_overflow = ovf_q;
    assign ALU_con_met  = cm_q;
    assign ALU_zero     = zero_q;
    assign ALU_err      = err_q;
    assign ALU_ready    = ready_q;

endmodule

// File: tb/tb_alu_top.sv
// Self-checking bench for alu_top: directed and randomized operations against a behavioural model.
module tb_alu_top;

    logic        clk;
    logic        rst;
    logic        dat_ready;
    logic [31:0] dat1, dat2;
    logic [2:0]  opcode;
    logic        opdiff;
    logic        optype;
    logic [4:0]  instr;
    logic        ovf, con_met, zero, err, ready;
    logic [31:0] out;

    int n_checks = 0;
    int n_fail   = 0;

    alu_top dut (
        .soc_clk                   (clk),
        .reset                     (rst),
        .dat_ready                 (dat_ready),
        .ALU_dat1                  (dat1),
        .ALU_dat2                  (dat2),
        .ALU_opcode                (opcode),
        .ALU_opcode_differentiator (opdiff),
        .ALU_optype                (optype),
        .Instruction_to_ALU        (instr),
        .ALU_overflow              (ovf),
        .ALU_con_met               (con_met),
        .ALU_zero                  (zero),
        .ALU_err                   (err),
        .ALU_ready                 (ready),
        .ALU_out                   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference written from the operation table.
    function automatic void model(input logic [4:0] idx_in, input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] f3, input logic df, input logic ot,
                                  output logic [31:0] e_out, output logic e_ovf, output logic e_cm,
                                  output logic e_zero, output logic e_err);
        int    idx;
        longint sa, sb, r;
        idx = int'(idx_in);
`ifdef ALU_DECODE_EN
        if (idx >= 16) begin
            if (ot) begin
                case (f3)
                    3'd0: idx = 0;  3'd1: idx = 1;  3'd4: idx = 2;
                    3'd5: idx = 3;  3'd6: idx = 4;  3'd7: idx = 5;
                    default: idx = 16;
                endcase
            end else begin
                case (f3)
                    3'd0: idx = df ? 7 : 6;
                    3'd1: idx = 8;  3'd2: idx = 9;  3'd3: idx = 10;  3'd4: idx = 11;
                    3'd5: idx = df ? 13 : 12;
                    3'd6: idx = 14;
                    default: idx = 15;
                endcase
            end
        end
`else
        if (f3 == 3'd0 && df && ot) idx = idx;
`endif
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e_out = 32'd0; e_ovf = 1'b0; e_cm = 1'b0; e_err = 1'b0;
        case (idx)
            0: e_cm = (a == b);
            1: e_cm = (a != b);
            2: e_cm = (sa < sb);
            3: e_cm = (sa >= sb);
            4: e_cm = (a < b);
            5: e_cm = (a >= b);
            6: begin r = sa + sb; e_out = r[31:0]; e_ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            7: begin r = sa - sb; e_out = r[31:0]; e_ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            8:  e_out = a << b[4:0];
            9:  e_out = (sa < sb) ? 32'd1 : 32'd0;
            10: e_out = (a < b) ? 32'd1 : 32'd0;
            11: e_out = a ^ b;
            12: e_out = a >> b[4:0];
            13: e_out = $unsigned($signed(a) >>> b[4:0]);
            14: e_out = a | b;
            15: e_out = a & b;
            default: e_err = 1'b1;
        endcase
        if (idx <= 5) e_out = {31'd0, e_cm};
        e_zero = !e_err && (e_out == 32'd0);
    endfunction

    task automatic drive(input logic [4:0] idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic df, input logic ot);
        instr = idx; dat1 = a; dat2 = b; opcode = f3; opdiff = df; optype = ot;
        dat_ready = 1'b1;
    endtask

    task automatic scramble();
        dat1 = $urandom; dat2 = $urandom; instr = 5'($urandom); opcode = 3'($urandom);
        opdiff = 1'($urandom); optype = 1'($urandom);
    endtask

    task automatic check_result(input string name, input logic [31:0] e_out, input logic e_ovf,
                                input logic e_cm, input logic e_zero, input logic e_err);
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL %s ready: got %b expected 1", name, ready); end
        n_checks++;
        if (out !== e_out) begin n_fail++; $display("FAIL %s out: got %h expected %h", name, out, e_out); end
        n_checks++;
        if (ovf !== e_ovf) begin n_fail++; $display("FAIL %s overflow: got %b expected %b", name, ovf, e_ovf); end
        n_checks++;
        if (con_met !== e_cm) begin n_fail++; $display("FAIL %s con_met: got %b expected %b", name, con_met, e_cm); end
        n_checks++;
        if (err !== e_err) begin n_fail++; $display("FAIL %s err: got %b expected %b", name, err, e_err); end
        if (!e_err) begin
            n_checks++;
            if (zero !== e_zero) begin n_fail++; $display("FAIL %s zero: got %b expected %b", name, zero, e_zero); end
        end
    endtask

    task automatic do_op(input string name, input logic [4:0] idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic df, input logic ot);
        logic [31:0] e_out;
        logic e_ovf, e_cm, e_zero, e_err;
        model(idx, a, b, f3, df, ot, e_out, e_ovf, e_cm, e_zero, e_err);
        @(negedge clk);
        drive(idx, a, b, f3, df, ot);
        @(posedge clk); #1;
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL %s early_ready: got %b expected 0", name, ready); end
        scramble();
        @(posedge clk); #1;
        check_result(name, e_out, e_ovf, e_cm, e_zero, e_err);
        @(negedge clk);
        dat_ready = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (ready !== 1'b0 || out !== e_out) begin
            n_fail++; $display("FAIL %s release: ready %b out %h expected ready 0 out %h", name, ready, out, e_out);
        end
        $display("op %-10s idx=%0d a=%h b=%h -> out=%h ovf=%b cm=%b z=%b err=%b", name, idx, a, b, out, ovf, con_met, zero, err);
    endtask

    task automatic test_reset();
        rst = 1'b1; dat_ready = 1'b0;
        dat1 = '0; dat2 = '0; opcode = '0; opdiff = 1'b0; optype = 1'b0; instr = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({ready, err, zero, con_met, ovf, out} !== 37'd0) begin
            n_fail++; $display("FAIL reset_state: got ready %b err %b zero %b cm %b ovf %b out %h expected all 0",
                               ready, err, zero, con_met, ovf, out);
        end
        @(negedge clk); rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_directed();
        do_op("add",     5'd6,  32'h5,        32'h3,        3'd0, 1'b0, 1'b0);
        do_op("sub",     5'd7,  32'h5,        32'h3,        3'd0, 1'b0, 1'b0);
        do_op("add_ovf", 5'd6,  32'h7FFFFFFF, 32'h1,        3'd0, 1'b0, 1'b0);
        do_op("sub_ovf", 5'd7,  32'h80000000, 32'h1,        3'd0, 1'b0, 1'b0);
        do_op("sub_zero",5'd7,  32'h3,        32'h3,        3'd0, 1'b0, 1'b0);
        do_op("sll",     5'd8,  32'h3,        32'h2,        3'd0, 1'b0, 1'b0);
        do_op("srl",     5'd12, 32'hF0000000, 32'h4,        3'd0, 1'b0, 1'b0);
        do_op("sra",     5'd13, 32'hF0000000, 32'h4,        3'd0, 1'b0, 1'b0);
        do_op("xor",     5'd11, 32'h0F0F0F0F, 32'hFF00FF00, 3'd0, 1'b0, 1'b0);
        do_op("or",      5'd14, 32'h0F0F0F0F, 32'hFF00FF00, 3'd0, 1'b0, 1'b0);
        do_op("and",     5'd15, 32'h0F0F0F0F, 32'hFF00FF00, 3'd0, 1'b0, 1'b0);
        do_op("slt",     5'd9,  32'h3,        32'h5,        3'd0, 1'b0, 1'b0);
        do_op("sltu",    5'd10, 32'hFFFFFFFF, 32'h1,        3'd0, 1'b0, 1'b0);
        do_op("beq",     5'd0,  32'h5,        32'h5,        3'd0, 1'b0, 1'b0);
        do_op("bne",     5'd1,  32'h5,        32'h3,        3'd0, 1'b0, 1'b0);
        do_op("blt",     5'd2,  32'hFFFFFFFD, 32'h0,        3'd0, 1'b0, 1'b0);
        do_op("bge",     5'd3,  32'h0,        32'hFFFFFFFD, 3'd0, 1'b0, 1'b0);
        do_op("bltu",    5'd4,  32'h3,        32'h5,        3'd0, 1'b0, 1'b0);
        do_op("bgeu",    5'd5,  32'h3,        32'h5,        3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_illegal();
        do_op("pre_ill", 5'd14, 32'h12340000, 32'h00005678, 3'd0, 1'b0, 1'b0);
        do_op("illegal", 5'd16, 32'hDEADBEEF, 32'h1,        3'd2, 1'b0, 1'b1);
        do_op("ill_31",  5'd31, 32'h1,        32'h1,        3'd3, 1'b0, 1'b1);
        do_op("err_clr", 5'd6,  32'h1,        32'h1,        3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            do_op("rand", 5'($urandom_range(0, 19)), $urandom, $urandom,
                  3'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_hold();
        logic [31:0] e_out;
        logic e_ovf, e_cm, e_zero, e_err;
        model(5'd6, 32'h100, 32'h23, 3'd0, 1'b0, 1'b0, e_out, e_ovf, e_cm, e_zero, e_err);
        @(negedge clk);
        drive(5'd6, 32'h100, 32'h23, 3'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_result("hold", e_out, e_ovf, e_cm, e_zero, e_err);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); scramble();
            @(posedge clk); #1;
            n_checks++;
            if (ready !== 1'b1 || out !== e_out) begin
                n_fail++; $display("FAIL hold_cycle%0d: ready %b out %h expected ready 1 out %h", i, ready, out, e_out);
            end
        end
        @(negedge clk); dat_ready = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL hold_release: ready %b expected 0", ready); end
        $display("hold test done out=%h", out);
    endtask

    task automatic test_drop_in_exec();
        logic [31:0] e_out;
        logic e_ovf, e_cm, e_zero, e_err;
        model(5'd7, 32'h10, 32'h30, 3'd0, 1'b0, 1'b0, e_out, e_ovf, e_cm, e_zero, e_err);
        @(negedge clk);
        drive(5'd7, 32'h10, 32'h30, 3'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        dat_ready = 1'b0;
        scramble();
        @(posedge clk); #1;
        check_result("drop_exec", e_out, e_ovf, e_cm, e_zero, e_err);
        @(posedge clk); #1;
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL drop_exec_release: ready %b expected 0", ready); end
        $display("drop-in-exec done out=%h", out);
    endtask

    task automatic test_reset_mid_exec();
        do_op("pre_rst", 5'd15, 32'hFFFF0000, 32'hF0F0F0F0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        drive(5'd6, 32'h7FFFFFFF, 32'h1, 3'd0, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ready, err, zero, con_met, ovf, out} !== 37'd0) begin
            n_fail++; $display("FAIL reset_mid_exec: ready %b err %b zero %b cm %b ovf %b out %h expected all 0",
                               ready, err, zero, con_met, ovf, out);
        end
        @(negedge clk); rst = 1'b0; dat_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (ready !== 1'b0 || out !== 32'd0) begin
                n_fail++; $display("FAIL reset_no_ready%0d: ready %b out %h expected 0 and 0", i, ready, out);
            end
        end
        $display("reset mid-exec done");
        do_op("post_rst", 5'd6, 32'h5, 32'h3, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_hold();
        test_drop_in_exec();
        test_random();
        test_reset_mid_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
